// File: rtl/scratchpad_regfile_param_pkg.sv
// rtl/scratchpad_regfile_param_pkg.sv - index map, reset defaults and readability helper for the scratchpad
package scratchpad_pkg;

  localparam int R0_IDX                 = 0;
  localparam int DEFAULT_PC_RESET_VALUE = 2048;
  localparam int DEFAULT_PC_STEP        = 4;

  function automatic int pc_idx(input int num_regs);
    return num_regs - 2;
  endfunction

  function automatic int ir_idx(input int num_regs);
    return num_regs - 1;
  endfunction

  // A/B ports see general registers and PC only; r0, IR and out-of-range read as zero.
  function automatic logic is_readable(input int idx, input int num_regs);
    return (idx > R0_IDX) && (idx < num_regs) && (idx != ir_idx(num_regs));
  endfunction

endpackage

// File: rtl/scratchpad_regfile_param_if.sv
// rtl/scratchpad_regfile_param_if.sv - control-unit to scratchpad bus bundle
interface scratchpad_regfile_param_if #(
  parameter int DATAWIDTH_DATA = 32,
  parameter int SEL_WIDTH      = 6
);
  logic [SEL_WIDTH-1:0]      Amux_Selector;
  logic [SEL_WIDTH-1:0]      Bmux_Selector;
  logic [SEL_WIDTH-1:0]      Cmux_Selector;
  logic                      Cmux_Write;
  logic [DATAWIDTH_DATA-1:0] Cmux_BUS_DATA;
  logic                      PC_Increment;
  logic [DATAWIDTH_DATA-1:0] Amux_BUS_DATA;
  logic [DATAWIDTH_DATA-1:0] Bmux_BUS_DATA;
  logic [DATAWIDTH_DATA-1:0] IR_DATA_BUS;
  logic [DATAWIDTH_DATA-1:0] PC_DATA_BUS;
  logic                      Sel_Error;

  modport master (
    output Amux_Selector, Bmux_Selector, Cmux_Selector, Cmux_Write, Cmux_BUS_DATA, PC_Increment,
    input  Amux_BUS_DATA, Bmux_BUS_DATA, IR_DATA_BUS, PC_DATA_BUS, Sel_Error
  );

  modport slave (
    input  Amux_Selector, Bmux_Selector, Cmux_Selector, Cmux_Write, Cmux_BUS_DATA, PC_Increment,
    output Amux_BUS_DATA, Bmux_BUS_DATA, IR_DATA_BUS, PC_DATA_BUS, Sel_Error
  );
endinterface

// File: rtl/scratchpad_pc_counter.sv
// rtl/scratchpad_pc_counter.sv - PC register with load-over-increment priority and read-view output
module scratchpad_pc_counter #(
  parameter int W           = 32,
  parameter int RESET_VALUE = 2048,
  parameter int STEP        = 4,
  parameter bit RD_BYPASS   = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_en,
  input  logic [W-1:0] load_data,
  input  logic         inc_en,
  output logic [W-1:0] pc_o,
  output logic [W-1:0] pc_rd_o
);
  logic [W-1:0] pc_q;
  logic [W-1:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load_en) begin
      pc_d = load_data;
    end else if (inc_en) begin
      pc_d = pc_q + W'(STEP);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= W'(RESET_VALUE);
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o    = pc_q;
  // Value the A/B read ports should see for a same-edge read of the PC.
  assign pc_rd_o = RD_BYPASS ? pc_d : pc_q;
endmodule

// File: rtl/scratchpad_regfile_param.sv
// rtl/scratchpad_regfile_param.sv - parametrised scratchpad register file; SCRATCHPAD_RD_BYPASS_EN selects write-first reads
module scratchpad_regfile_param
  import scratchpad_pkg::*;
#(
  parameter int DATAWIDTH_DATA = 32,
  parameter int NUM_REGS       = 8,
  parameter int SEL_WIDTH      = 6,
  parameter int PC_RESET_VALUE = DEFAULT_PC_RESET_VALUE,
  parameter int PC_STEP        = DEFAULT_PC_STEP
) (
  input logic                       Clock,
  input logic                       Reset,
  scratchpad_regfile_param_if.slave bus
);
  localparam int IDX_W  = $clog2(NUM_REGS);
  localparam int PC_IDX = pc_idx(NUM_REGS);
  localparam int IR_IDX = ir_idx(NUM_REGS);
`ifdef SCRATCHPAD_RD_BYPASS_EN
  localparam bit RD_BYPASS = 1'b1;
`else
  localparam bit RD_BYPASS = 1'b0;
`endif

  typedef logic [DATAWIDTH_DATA-1:0] word_t;

  // PC and r0 slots of this array are never written and stay zero.
  word_t regs_q [NUM_REGS];
  word_t regs_d [NUM_REGS];
  word_t amux_q, amux_d;
  word_t bmux_q, bmux_d;
  logic  sel_error_q, sel_error_d;
  logic  wr_valid;
  logic  pc_load;
  word_t pc_cur;
  word_t pc_rd;

  assign wr_valid = bus.Cmux_Write && (int'(bus.Cmux_Selector) < NUM_REGS)
                    && (int'(bus.Cmux_Selector) != R0_IDX);
  assign pc_load  = wr_valid && (int'(bus.Cmux_Selector) == PC_IDX);

  scratchpad_pc_counter #(
    .W          (DATAWIDTH_DATA),
    .RESET_VALUE(PC_RESET_VALUE),
    .STEP       (PC_STEP),
    .RD_BYPASS  (RD_BYPASS)
  ) u_pc (
    .clk      (Clock),
    .rst      (Reset),
    .load_en  (pc_load),
    .load_data(bus.Cmux_BUS_DATA),
    .inc_en   (bus.PC_Increment),
    .pc_o     (pc_cur),
    .pc_rd_o  (pc_rd)
  );

  function automatic word_t read_port(input logic [SEL_WIDTH-1:0] sel);
    word_t v;
    v = '0;
    if (is_readable(int'(sel), NUM_REGS)) begin
      if (int'(sel) == PC_IDX) begin
        v = pc_rd;
      end else begin
        v = RD_BYPASS ? regs_d[sel[IDX_W-1:0]] : regs_q[sel[IDX_W-1:0]];
      end
    end
    return v;
  endfunction

  always_comb begin
    regs_d = regs_q;
    if (wr_valid && !pc_load) begin
      regs_d[bus.Cmux_Selector[IDX_W-1:0]] = bus.Cmux_BUS_DATA;
    end
    amux_d      = read_port(bus.Amux_Selector);
    bmux_d      = read_port(bus.Bmux_Selector);
    sel_error_d = sel_error_q
                  || (int'(bus.Amux_Selector) >= NUM_REGS)
                  || (int'(bus.Bmux_Selector) >= NUM_REGS)
                  || (bus.Cmux_Write && (int'(bus.Cmux_Selector) >= NUM_REGS));
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      amux_q      <= '0;
      bmux_q      <= '0;
      sel_error_q <= 1'b0;
    end else begin
      regs_q      <= regs_d;
      amux_q      <= amux_d;
      bmux_q      <= bmux_d;
      sel_error_q <= sel_error_d;
    end
  end

  assign bus.Amux_BUS_DATA = amux_q;
  assign bus.Bmux_BUS_DATA = bmux_q;
  assign bus.IR_DATA_BUS   = regs_q[IR_IDX];
  assign bus.PC_DATA_BUS   = pc_cur;
  assign bus.Sel_Error     = sel_error_q;
endmodule

// File: tb/tb_scratchpad_regfile_param.sv
// tb/tb_scratchpad_regfile_param.sv - directed and random checks of scratchpad_regfile_param against a register-map model
module tb_scratchpad_regfile_param;
  localparam int N      = 8;
  localparam int PC_I   = 6;
  localparam int IR_I   = 7;
  localparam int PC_RST = 2048;
`ifdef SCRATCHPAD_RD_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  typedef logic [31:0] mem_t [N];

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  scratchpad_regfile_param_if #(.DATAWIDTH_DATA(32), .SEL_WIDTH(6)) bus_if ();

  scratchpad_regfile_param #(
    .DATAWIDTH_DATA(32), .NUM_REGS(N), .SEL_WIDTH(6), .PC_RESET_VALUE(PC_RST), .PC_STEP(4)
  ) dut (
    .Clock(clk),
    .Reset(rst),
    .bus  (bus_if.slave)
  );

  mem_t        mem;
  logic        err_m;
  logic [31:0] exp_a, exp_b;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] view_rd(input int idx, input mem_t v);
    return (idx >= 1 && idx <= PC_I) ? v[idx] : 32'h0;
  endfunction

  // Apply one clock of stimulus, advance the model, then compare all outputs.
  task automatic step(input logic r, input int a, input int b, input int c,
                      input logic we, input logic [31:0] d, input logic inc);
    mem_t old_v;
    rst                  = r;
    bus_if.Amux_Selector = 6'(a);
    bus_if.Bmux_Selector = 6'(b);
    bus_if.Cmux_Selector = 6'(c);
    bus_if.Cmux_Write    = we;
    bus_if.Cmux_BUS_DATA = d;
    bus_if.PC_Increment  = inc;
    @(posedge clk);
    old_v = mem;
    if (r) begin
      foreach (mem[i]) mem[i] = 32'h0;
      mem[PC_I] = PC_RST;
      err_m = 1'b0;
      exp_a = 32'h0;
      exp_b = 32'h0;
    end else begin
      if (a >= N || b >= N || (we && c >= N)) err_m = 1'b1;
      if (inc && !(we && c == PC_I)) mem[PC_I] = mem[PC_I] + 32'd4;
      if (we && c > 0 && c < N) mem[c] = d;
      exp_a = view_rd(a, BYPASS ? mem : old_v);
      exp_b = view_rd(b, BYPASS ? mem : old_v);
    end
    #1;
    chk("amux", bus_if.Amux_BUS_DATA, exp_a);
    chk("bmux", bus_if.Bmux_BUS_DATA, exp_b);
    chk("pc", bus_if.PC_DATA_BUS, mem[PC_I]);
    chk("ir", bus_if.IR_DATA_BUS, mem[IR_I]);
    chk("sel_error", 32'(bus_if.Sel_Error), 32'(err_m));
  endtask

  initial begin
    foreach (mem[i]) mem[i] = 32'h0;
    err_m = 1'b0;
    exp_a = 32'h0;
    exp_b = 32'h0;

    step(1, 0, 0, 0, 0, 32'h0, 0);
    chk("reset_pc", bus_if.PC_DATA_BUS, 32'd2048);
    chk("reset_ir", bus_if.IR_DATA_BUS, 32'h0);
    chk("reset_err", 32'(bus_if.Sel_Error), 32'h0);
    for (int i = 1; i <= 5; i++) begin
      step(0, i, 0, 0, 0, 32'h0, 0);
      chk("reset_read_zero", bus_if.Amux_BUS_DATA, 32'h0);
    end

    step(0, 0, 0, 3, 1, 32'hDEADBEEF, 0);
    step(0, 3, 3, 0, 0, 32'h0, 0);
    step(0, 0, 0, 0, 0, 32'h0, 0);
    step(0, 3, 3, 0, 1, 32'h1234, 0);
    chk("r3_a", bus_if.Amux_BUS_DATA, 32'hDEADBEEF);
    chk("r3_b", bus_if.Bmux_BUS_DATA, 32'hDEADBEEF);
    step(0, 0, 0, 0, 0, 32'h0, 0);
    chk("r0_read", bus_if.Amux_BUS_DATA, 32'h0);

    step(0, 0, 0, 2, 1, 32'h11111111, 0);
    step(0, 2, 0, 2, 1, 32'hA5A5A5A5, 0);
    chk("conflict_a", bus_if.Amux_BUS_DATA, BYPASS ? 32'hA5A5A5A5 : 32'h11111111);
    step(0, 2, 0, 0, 0, 32'h0, 0);
    chk("conflict_after", bus_if.Amux_BUS_DATA, 32'hA5A5A5A5);

    for (int i = 0; i < 3; i++) begin
      step(0, PC_I, 0, 0, 0, 32'h0, 1);
      chk("pc_inc", bus_if.PC_DATA_BUS, 32'(PC_RST + 4 * (i + 1)));
    end
    step(0, 0, PC_I, PC_I, 1, 32'h100, 1);
    chk("pc_load_wins", bus_if.PC_DATA_BUS, 32'h100);
    step(0, 0, 0, PC_I, 1, 32'hFFFFFFFC, 0);
    step(0, PC_I, 0, 0, 0, 32'h0, 1);
    chk("pc_wrap", bus_if.PC_DATA_BUS, 32'h0);

    step(0, 0, 0, IR_I, 1, 32'h8C00A001, 0);
    chk("ir_write", bus_if.IR_DATA_BUS, 32'h8C00A001);
    step(0, IR_I, IR_I, 0, 0, 32'h0, 0);
    chk("ir_a_zero", bus_if.Amux_BUS_DATA, 32'h0);

    step(0, 9, 0, 0, 0, 32'h0, 0);
    chk("oor_a_zero", bus_if.Amux_BUS_DATA, 32'h0);
    chk("oor_err", 32'(bus_if.Sel_Error), 32'h1);
    step(0, 1, 1, 0, 0, 32'h0, 0);
    chk("err_sticky", 32'(bus_if.Sel_Error), 32'h1);
    step(1, 0, 0, 1, 1, 32'hCAFEF00D, 1);
    step(0, 1, 0, 0, 0, 32'h0, 0);
    chk("reset_drops_write", bus_if.Amux_BUS_DATA, 32'h0);
    chk("reset_clears_err", 32'(bus_if.Sel_Error), 32'h0);

    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 59) == 0),
           int'($urandom_range(0, 9)), int'($urandom_range(0, 9)), int'($urandom_range(0, 9)),
           $urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 2) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/scratchpad_regfile_param.md
Name: scratchpad_regfile_param

Overview:
Parametrised successor to the fixed 8-entry datapath scratchpad. It provides a configurable-depth register file with a hardwired-zero r0, general registers, a PC with auto-increment, and an IR. Read ports are registered, and the write port has an explicit enable. It sits between the control unit (selectors, strobes) and the ALU A/B buses, and feeds IR to the control decoder.

Parameters:
DATAWIDTH_DATA, 32, width of every register and bus
NUM_REGS, 8, total register indices; minimum 4
SEL_WIDTH, 6, selector width; must satisfy 2**SEL_WIDTH >= NUM_REGS
PC_RESET_VALUE, 2048, PC value after reset
PC_STEP, 4, PC increment per PC_Increment strobe

Ports:
Clock  in  1  system clock, rising edge
Reset  in  1  synchronous, active-high reset
Amux_Selector  in  SEL_WIDTH  read index, A port
Bmux_Selector  in  SEL_WIDTH  read index, B port
Cmux_Selector  in  SEL_WIDTH  write index
Cmux_Write  in  1  write enable, active-high
Cmux_BUS_DATA  in  DATAWIDTH_DATA  write data
PC_Increment  in  1  strobe: PC += PC_STEP
Amux_BUS_DATA  out  DATAWIDTH_DATA  registered A read data
Bmux_BUS_DATA  out  DATAWIDTH_DATA  registered B read data
IR_DATA_BUS  out  DATAWIDTH_DATA  current IR contents, direct from the register
PC_DATA_BUS  out  DATAWIDTH_DATA  current PC contents, direct from the register
Sel_Error  out  1  sticky flag for an out-of-range selector

Behaviour:
- Index map: 0 = r0, reads 0 and ignores writes. 1..NUM_REGS-3 = general. NUM_REGS-2 = PC. NUM_REGS-1 = IR. Indices >= NUM_REGS are out of range.
- Reset, sampled at a rising Clock edge with Reset=1:
  - general registers and IR go to 0
  - PC goes to PC_RESET_VALUE
  - Amux_BUS_DATA, Bmux_BUS_DATA and Sel_Error go to 0
  - Reset overrides every other input in the same cycle
  - reset mid-operation discards any write or increment presented that cycle
- Write: on an edge with Cmux_Write=1, register[Cmux_Selector] <= Cmux_BUS_DATA.
  - Writes to index 0 or out-of-range indices are dropped.
  - With Cmux_Write=0, no register changes except PC via increment.
- PC:
  - PC_Increment=1 gives PC <= PC + PC_STEP, modulo 2**DATAWIDTH_DATA (wraps silently).
  - A simultaneous C write to the PC index wins; the increment is discarded that cycle.
- Reads have 1-cycle latency: selectors sampled at edge N appear on Amux/Bmux_BUS_DATA after edge N.
  - Index 0 reads 0.
  - Index NUM_REGS-1 (IR) reads 0 on A/B; IR is visible only on IR_DATA_BUS.
  - Out-of-range indices read 0.
  - Both ports may select the same index freely.
- Read-during-write to the same index in the same cycle is governed by the optional feature below.
- PC read-during-increment follows the same rule as read-during-write.
- Sel_Error is set at an edge when:
  - any A/B selector is >= NUM_REGS, or
  - Cmux_Write=1 with Cmux_Selector >= NUM_REGS.
  It stays set until Reset.
- IR_DATA_BUS and PC_DATA_BUS update the cycle after their write or increment; they have no bypass.

Optional Feature:
Macro SCRATCHPAD_RD_BYPASS_EN.
- Defined: write-first. A read of the index being written (or of the PC while it increments) at the same edge returns the new value.
- Undefined: read-first. The read returns the pre-edge value; the new value is visible on the following read.

Decomposition:
- Package scratchpad_pkg holds:
  - index constants: R0_IDX=0, plus functions pc_idx(NUM_REGS) and ir_idx(NUM_REGS)
  - default PC_RESET_VALUE and PC_STEP
  - a function is_readable(idx, NUM_REGS)
- One sub-module, scratchpad_pc_counter, owns:
  - PC storage
  - reset value
  - the priority between load and increment
  - its bypass value output

Test Plan:
- Reset: assert Reset 1 cycle -> PC_DATA_BUS=2048, IR_DATA_BUS=0, A/B=0, Sel_Error=0. Then select index 1..5 on A -> 0 each cycle.
- Write/read: write 0xDEADBEEF to r3, next cycle A=3, B=3 -> both 0xDEADBEEF one cycle later. Write 0x1234 to r0, then read r0 -> 0.
- Same-cycle conflict: write 0xA5A5A5A5 to r2 while A selects 2.
  - Bypass on -> A=0xA5A5A5A5 next cycle.
  - Bypass off -> old r2, then 0xA5A5A5A5 a cycle later.
- PC:
  - 3 consecutive PC_Increment -> PC_DATA_BUS 2052, 2056, 2060.
  - C write 0x100 to the PC index with PC_Increment=1 -> PC=0x100.
  - PC=0xFFFFFFFC plus increment -> 0.
- IR: write 0x8C00A001 to index NUM_REGS-1 -> IR_DATA_BUS=0x8C00A001 next cycle. A/B selecting IR index -> 0.
- Range and reset: NUM_REGS=8, A selector=9 -> A=0, Sel_Error=1 and sticky. Reset asserted together with a write to r1 -> r1 stays 0, Sel_Error clears.
